// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage issuing word loads/stores on a req/ack bus with timeout
package mem_stage_pkg;
  typedef enum logic [1:0] {OP_NONE = 2'b00, OP_LOAD = 2'b01, OP_STORE = 2'b10, OP_RSVD = 2'b11} mem_op_t;
  typedef logic [3:0] wrstb_t;
  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    mem_op_t     mem_op;
    logic [31:0] mem_data;
  } mem_params_t;
  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
  } wb_params_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  mem_params_t mem_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output wb_params_t  wb_o,
  output logic        bus_err_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output wrstb_t      dbus_wrstb_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state, state_n;
  logic [15:0] cnt;
  logic [4:0]  rd_lat;
  logic        is_mem, start, ack_done, tmo_done;
  assign stall_o = state == BUSY;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // ack is checked first so a completion on the last allowed cycle is never reported as a timeout
  always_comb begin
    is_mem   = mem_i.mem_op == OP_LOAD || mem_i.mem_op == OP_STORE;
    start    = state == IDLE && mem_valid_i && is_mem;
    ack_done = state == BUSY && dbus_ack_i;
    tmo_done = state == BUSY && !dbus_ack_i && cnt == 16'(TIMEOUT - 1);
    state_n  = start ? BUSY : (ack_done || tmo_done) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_o   <= 1'b0;
      wb_o         <= '0;
      bus_err_o    <= 1'b0;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_wdata_o <= '0;
      dbus_wrstb_o <= '0;
      rd_lat       <= '0;
      cnt          <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      bus_err_o  <= 1'b0;
      if (state == IDLE) begin
        if (mem_valid_i && !is_mem) begin
          wb_o       <= {mem_i.rd_addr, mem_i.rd_data};
          wb_valid_o <= 1'b1;
        end
        if (start) begin
          dbus_req_o   <= 1'b1;
          dbus_we_o    <= mem_i.mem_op == OP_STORE;
          dbus_addr_o  <= {mem_i.rd_data[31:2], 2'b00};
          dbus_wdata_o <= mem_i.mem_data;
          dbus_wrstb_o <= mem_i.mem_op == OP_STORE ? 4'b1111 : 4'b0000;
          rd_lat       <= mem_i.rd_addr;
          cnt          <= '0;
        end
      end else if (ack_done || tmo_done) begin
        dbus_req_o <= 1'b0;
        wb_valid_o <= 1'b1;
        bus_err_o  <= tmo_done;
        wb_o       <= dbus_we_o ? '0 : {rd_lat, ack_done ? dbus_rdata_i : 32'd0};
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline memory-access stage between the EX/MEM register and the MEM/WB register. It consumes a `mem_params_t` and issues word loads and stores on a request/acknowledge data bus. It stalls the upstream pipeline while a bus access is outstanding and produces a registered `wb_params_t` for writeback. A programmable timeout ensures that a dead bus cannot hang the core.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of BUSY cycles without `dbus_ack` before the access is aborted. Legal range 1..65535.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_valid_i`  in  1  `mem_i` holds a valid instruction.
- `mem_i`  in  71  `mem_params_t`:
  - `rd_addr`: destination register.
  - `rd_data`: ALU result, also the memory address for loads and stores.
  - `mem_op`: NONE, LOAD or STORE.
  - `mem_data`: store data.
- `stall_o`  out  1  upstream must hold `mem_i`/`mem_valid_i` this cycle.
- `wb_valid_o`  out  1  `wb_o` is valid for one cycle.
- `wb_o`  out  37  `wb_params_t`: `rd_addr`, `rd_data`.
- `bus_err_o`  out  1  one-cycle pulse when an access is aborted by timeout.
- `dbus_req_o`  out  1  bus request.
- `dbus_we_o`  out  1  1 = write, 0 = read.
- `dbus_addr_o`  out  32  word-aligned byte address.
- `dbus_wdata_o`  out  32  store data.
- `dbus_wrstb_o`  out  4  `wrstb_t` byte-lane write strobes.
- `dbus_ack_i`  in  1  bus completes the access this cycle.
- `dbus_rdata_i`  in  32  read data, valid when `dbus_ack_i`=1 and the access is a read.

## Operation
- FSM with two states:
  - IDLE: reset state.
  - BUSY: bus access outstanding.
- `stall_o` = (state == BUSY). It is combinational from state only and has no path from `dbus_ack_i`.
- IDLE, `mem_valid_i`=0: `wb_valid_o` <= 0.
- IDLE, `mem_valid_i`=1, `mem_op`=NONE:
  - `wb_o` <= {`rd_addr`, `rd_data`}.
  - `wb_valid_o` <= 1.
  - Stay in IDLE.
- IDLE, `mem_valid_i`=1, `mem_op`=LOAD or STORE:
  - Latch the bus fields:
    - `dbus_addr_o` <= {`rd_data[31:2]`, 2'b00}; address bits [1:0] are ignored.
    - `dbus_we_o` <= (op == STORE).
    - `dbus_wdata_o` <= `mem_data`.
    - `dbus_wrstb_o` <= 4'b1111 for a store, 4'b0000 for a load.
  - Latch `rd_addr`.
  - `dbus_req_o` <= 1; clear the timeout counter.
  - `wb_valid_o` <= 0; go to BUSY.
- `mem_op` = 2'b11 is treated as NONE.
- BUSY:
  - `dbus_req_o` and all `dbus_*` outputs are held stable until the access ends.
  - `mem_valid_i` is ignored; upstream is stalled.
  - The counter increments each BUSY cycle without ack.
- BUSY, `dbus_ack_i`=1:
  - `dbus_req_o` <= 0; `wb_valid_o` <= 1; go to IDLE.
  - Load: `wb_o` <= {latched `rd_addr`, `dbus_rdata_i`}.
  - Store: `wb_o` <= {5'd0, 32'd0}. r0 writes are discarded downstream.
- BUSY, no ack, counter reaches `TIMEOUT`:
  - `dbus_req_o` <= 0; `bus_err_o` <= 1 for one cycle; `wb_valid_o` <= 1; go to IDLE.
  - Load: `wb_o` <= {latched `rd_addr`, 32'd0}.
  - Store: `wb_o` <= {5'd0, 32'd0}.
- Ack and timeout in the same cycle: ack wins, and `bus_err_o` stays 0.
- `wb_valid_o` and `bus_err_o` are single-cycle pulses; they return to 0 on the next cycle unless a new completion occurs.

## Timing
- Reset values: state IDLE; every output is 0, including `wb_o`, all `dbus_*` outputs and `stall_o`.
- Reset during BUSY: the request is dropped on the next edge, and no writeback or error is produced.
- Pass-through (NONE): `wb_valid_o` rises 1 cycle after acceptance (cycle N accept, N+1 valid). The stage accepts back-to-back instructions every cycle.
- Memory op accepted in cycle N:
  - `dbus_req_o` and `stall_o` are high from N+1.
  - Ack sampled in cycle N+k (k ≥ 1): `wb_valid_o` is high in N+k+1, and `stall_o` is low in N+k+1.
  - Minimum load-to-writeback latency is 2 cycles.
- The instruction presented in N+1 is held by upstream and accepted in the first IDLE cycle, N+k+1. Its writeback can therefore follow the load's writeback with no gap.
- Timeout: with no ack, `dbus_req_o` is high for exactly `TIMEOUT` cycles, and `bus_err_o`/`wb_valid_o` are high in the following cycle.

## Test plan
- Reset then ALU op: `rd_addr`=3, `rd_data`=0x1234, op NONE → next cycle `wb_valid_o`=1, `wb_o`={3, 0x1234}, `stall_o`=0. Back-to-back NONE ops retire one per cycle.
- Load with zero wait: `rd_data`=0x1003, `rd_addr`=7, ack on the first req cycle with rdata 0xDEADBEEF → `dbus_addr_o`=0x1000, `dbus_wrstb_o`=0000, `wb_o`={7, 0xDEADBEEF} 2 cycles after acceptance, `stall_o` high for exactly 1 cycle.
- Store with 3 wait cycles: addr 0x20, data 0xA5A5A5A5 → `dbus_we_o`=1, `dbus_wrstb_o`=1111, outputs stable for 4 req cycles, `wb_o`={0, 0}, following NONE op retires in the cycle after the store.
- Timeout: `TIMEOUT`=4, load to r5, ack never asserted → req high 4 cycles, then `bus_err_o`=1 and `wb_o`={5, 0} for one cycle. Repeat with ack in the 4th cycle → no error, real data returned.
- Reset mid-access: assert `rst` on the 2nd BUSY cycle → all outputs 0 next cycle, no `wb_valid_o`. A new load after reset completes normally.
- `mem_valid_i` toggling during BUSY with different payloads → ignored. Only the held instruction is accepted after completion.
